test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
Parametrised test-run controller for the processor bench. It replaces hard-wired concurrent test instantiation: selected test channels run one at a time, in index order, on a shared clock. Each channel gets a start pulse and a per-channel reset release. Each channel's pass/fail is recorded, with a watchdog timeout per channel. The block sits beside the clock generator and drives all component and instruction tests; results feed a summary reporter.

Parameters:
NUM_TESTS, 16, number of test channels (1..64)
TIMEOUT, 1000, max cycles a channel may run before it is declared failed (>=2)
TIMER_W, 16, width of the watchdog and total-cycle counters; TIMEOUT < 2**TIMER_W
IDX_W, 4, width of the channel index; 2**IDX_W >= NUM_TESTS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a run (accepted in IDLE or DONE only)
enable_mask  in  NUM_TESTS  channels to run, sampled on accepted start
test_done  in  NUM_TESTS  per-channel completion strobe
test_pass  in  NUM_TESTS  per-channel result, valid with test_done
test_start  out  NUM_TESTS  one-hot one-cycle launch pulse
test_rst_n  out  NUM_TESTS  per-channel reset, low unless channel active
busy  out  1  high in LAUNCH/WAIT/SKIP
all_done  out  1  high in DONE
cur_idx  out  IDX_W  channel currently addressed
pass_mask  out  NUM_TESTS  channels that passed
fail_mask  out  NUM_TESTS  channels that failed (includes timeouts)
timeout_mask  out  NUM_TESTS  channels that timed out
total_cycles  out  TIMER_W  cycles from accepted start to DONE, saturating

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; all masks 0; test_start=0; test_rst_n all 0; cur_idx=0; total_cycles=0; busy=0; all_done=0. Reset mid-run aborts the run immediately and discards results.
- States: IDLE, SKIP, LAUNCH, WAIT, DONE.
- IDLE/DONE + start: latch enable_mask, clear all result masks and total_cycles, set cur_idx=0, go to SKIP.
- SKIP (1 cycle per index):
  - If enabled[cur_idx], go to LAUNCH.
  - Else if cur_idx==NUM_TESTS-1, go to DONE.
  - Else increment cur_idx.
- LAUNCH (1 cycle): test_start[cur_idx]=1; test_rst_n[cur_idx]=1; watchdog=0; go to WAIT.
- WAIT:
  - test_rst_n[cur_idx] stays 1; watchdog increments each cycle.
  - If test_done[cur_idx]: set pass_mask[cur_idx]=test_pass[cur_idx], else fail_mask[cur_idx]=1.
  - Else if watchdog==TIMEOUT-1: set fail_mask and timeout_mask at cur_idx.
  - After either event, drop test_rst_n[cur_idx] next cycle. Advance to cur_idx+1 in SKIP, or go to DONE if cur_idx==NUM_TESTS-1.
  - test_done and timeout in the same cycle: done wins (no timeout bit).
- test_done/test_pass on non-active channels are ignored at all times.
- start while busy is ignored.
- enable_mask all zero: run passes through NUM_TESTS SKIP cycles to DONE with empty masks.
- total_cycles increments every cycle outside IDLE/DONE and saturates at 2**TIMER_W-1.
- DONE: results held stable until the next accepted start or reset; test_rst_n all 0.
- Latency: from accepted start to the first test_start pulse is (index of the first enabled channel)+2 cycles.
- Outputs are registered; no combinational path from test_done to test_start.

Test Plan:
1. Reset/idle: rst_n=0 for 2 cycles, then 1 → all outputs 0, busy=0, all_done=0; start with enable_mask=0 → all_done after 16 cycles, masks 0.
2. Sequential pass/fail: enable_mask=16'h0007; ch0 done+pass after 5 cycles, ch1 done+fail, ch2 done+pass → pass_mask=0x0005, fail_mask=0x0002, timeout_mask=0. Exactly one test_start pulse per channel, in order 0,1,2.
3. Timeout: TIMEOUT=8, enable ch3 only, never assert done → timeout_mask=fail_mask=0x0008 after 8 WAIT cycles; test_rst_n[3] high exactly 9 cycles.
4. Simultaneous done and timeout: ch0 asserts done+pass on watchdog==TIMEOUT-1 → pass_mask bit0=1, timeout_mask=0. Stray test_done[5] during the ch0 run → no effect.
5. Restart/abort: start mid-run → ignored. rst_n=0 during WAIT on ch1 → IDLE with masks cleared. start in DONE → masks cleared and a new run begins.
6. Skip spacing: enable_mask=16'h8001 → ch15 test_start occurs 14 SKIP cycles after ch0 completes; total_cycles matches the counted cycles.

Source files
------------

// File: rtl/test_sequencer.sv
// Sequential test-run controller: launches each enabled channel in index order,
// gives it a private reset release, and records pass / fail / watchdog timeout.
module test_sequencer #(
  parameter int NUM_TESTS = 16,
  parameter int TIMEOUT   = 1000,
  parameter int TIMER_W   = 16,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] enable_mask,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic [NUM_TESTS-1:0] test_start,
  output logic [NUM_TESTS-1:0] test_rst_n,
  output logic                 busy,
  output logic                 all_done,
  output logic [IDX_W-1:0]     cur_idx,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic [TIMER_W-1:0]   total_cycles,
  output logic [2:0]           dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE or DONE;
  // test_done/test_pass are level samples honoured only for the channel in WAIT.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SKIP   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_TESTS-1:0] en_q, en_d;
  logic [NUM_TESTS-1:0] pass_q, pass_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [NUM_TESTS-1:0] tmo_q, tmo_d;
  logic [TIMER_W-1:0]   wd_q, wd_d;
  logic [TIMER_W-1:0]   total_q, total_d;
  logic [NUM_TESTS-1:0] tstart_q, tstart_d;
  logic [NUM_TESTS-1:0] trst_q, trst_d;

  logic                 last_idx;
  logic [NUM_TESTS-1:0] cur_sel;
  logic [NUM_TESTS-1:0] next_sel;
  logic                 chan_finished;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    en_d          = en_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    tmo_d         = tmo_q;
    wd_d          = wd_q;
    total_d       = total_q;
    chan_finished = 1'b0;
    last_idx      = (idx_q == IDX_W'(NUM_TESTS - 1));
    cur_sel       = NUM_TESTS'(1) << idx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          en_d    = enable_mask;
          pass_d  = '0;
          fail_d  = '0;
          tmo_d   = '0;
          total_d = '0;
          idx_d   = '0;
          state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        if (en_q[idx_q]) begin
          state_d = S_LAUNCH;
        end else if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // A completion in the watchdog's final cycle still counts as a completion.
        if (test_done[idx_q]) begin
          chan_finished = 1'b1;
          if (test_pass[idx_q]) begin
            pass_d = pass_q | cur_sel;
          end else begin
            fail_d = fail_q | cur_sel;
          end
        end else if (wd_q == TIMER_W'(TIMEOUT - 1)) begin
          chan_finished = 1'b1;
          fail_d        = fail_q | cur_sel;
          tmo_d         = tmo_q | cur_sel;
        end
        if (chan_finished) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SKIP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_SKIP || state_q == S_LAUNCH || state_q == S_WAIT) &&
        (total_q != {TIMER_W{1'b1}})) begin
      total_d = total_q + 1'b1;
    end

    // Channel strobes are computed from the next state so they leave a flop.
    next_sel = NUM_TESTS'(1) << idx_d;
    tstart_d = (state_d == S_LAUNCH) ? next_sel : '0;
    trst_d   = (state_d == S_LAUNCH || state_d == S_WAIT) ? next_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      en_q     <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      tmo_q    <= '0;
      wd_q     <= '0;
      total_q  <= '0;
      tstart_q <= '0;
      trst_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      wd_q     <= wd_d;
      total_q  <= total_d;
      tstart_q <= tstart_d;
      trst_q   <= trst_d;
    end
  end

  assign test_start   = tstart_q;
  assign test_rst_n   = trst_q;
  assign busy         = (state_q == S_SKIP) || (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign all_done     = (state_q == S_DONE);
  assign cur_idx      = idx_q;
  assign pass_mask    = pass_q;
  assign fail_mask    = fail_q;
  assign timeout_mask = tmo_q;
  assign total_cycles = total_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: launch order is scoreboarded through a
// queue, results and timing are checked against hand-derived values.
module tb_test_sequencer;

  localparam int N   = 16;
  localparam int TMO = 8;
  localparam int TW  = 16;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  enable_mask = '0;
  logic [N-1:0]  test_done = '0;
  logic [N-1:0]  test_pass = '0;
  logic [N-1:0]  test_start;
  logic [N-1:0]  test_rst_n;
  logic          busy;
  logic          all_done;
  logic [IW-1:0] cur_idx;
  logic [N-1:0]  pass_mask;
  logic [N-1:0]  fail_mask;
  logic [N-1:0]  timeout_mask;
  logic [TW-1:0] total_cycles;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_seen = 0;
  logic [IW-1:0] exp_q[$];

  test_sequencer #(.NUM_TESTS(N), .TIMEOUT(TMO), .TIMER_W(TW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable_mask(enable_mask),
    .test_done(test_done), .test_pass(test_pass), .test_start(test_start),
    .test_rst_n(test_rst_n), .busy(busy), .all_done(all_done), .cur_idx(cur_idx),
    .pass_mask(pass_mask), .fail_mask(fail_mask), .timeout_mask(timeout_mask),
    .total_cycles(total_cycles), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_seen <= busy_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [IW-1:0] e;
    if (test_start != '0) begin
      if (exp_q.size() == 0) begin
        check("launch_unexpected", 64'(test_start), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("launch_order", 64'(test_start), 64'(1) << e);
      end
    end
    if (all_done) check("rst_low_in_done", 64'(test_rst_n), 64'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [N-1:0] mask, output int s_cyc);
    start = 1'b1;
    enable_mask = mask;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_launch(input int ch);
    int t = 0;
    while (!test_start[ch] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("launch_seen_ch%0d", ch), 64'(test_start[ch]), 64'd1);
  endtask

  // Called at the launch negedge; completes when the watchdog reads k.
  task automatic respond(input int ch, input int k, input logic pass, output int d_cyc);
    repeat (k + 1) @(negedge clk);
    test_done[ch] = 1'b1;
    test_pass[ch] = pass;
    d_cyc = cyc;
    @(negedge clk);
    test_done[ch] = 1'b0;
    test_pass[ch] = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!all_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("run_completes", 64'(all_done), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, d, b0, cnt;

    // 1. reset and empty run
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    check("rst_test_rst_n", 64'(test_rst_n), 64'd0);
    check("rst_test_start", 64'(test_start), 64'd0);
    check("rst_cur_idx", 64'(cur_idx), 64'd0);
    check("rst_masks", 64'({pass_mask, fail_mask, timeout_mask}), 64'd0);
    check("rst_total", 64'(total_cycles), 64'd0);
    b0 = busy_seen;
    start_run('0, s);
    wait_done();
    check("empty_total", 64'(total_cycles), 64'd16);
    check("empty_busy_cycles", 64'(busy_seen - b0), 64'd16);
    check("empty_masks", 64'({pass_mask, fail_mask, timeout_mask}), 64'd0);

    // 2. sequential pass / fail / pass
    exp_q.push_back(IW'(0)); exp_q.push_back(IW'(1)); exp_q.push_back(IW'(2));
    start_run(16'h0007, s);
    wait_launch(0);
    check("first_launch_latency", 64'(cyc - s), 64'd2);
    respond(0, 4, 1'b1, d);
    wait_launch(1);
    respond(1, 1, 1'b0, d);
    wait_launch(2);
    respond(2, 0, 1'b1, d);
    wait_done();
    check("seq_pass", 64'(pass_mask), 64'h0005);
    check("seq_fail", 64'(fail_mask), 64'h0002);
    check("seq_tmo", 64'(timeout_mask), 64'h0000);
    // ch0: 1 SKIP+1 LAUNCH+5 WAIT, ch1: 1+1+2, ch2: 1+1+1, then SKIP 3..15
    check("seq_total", 64'(total_cycles), 64'd27);

    // 3. watchdog timeout on ch3
    exp_q.push_back(IW'(3));
    start_run(16'h0008, s);
    wait_launch(3);
    check("ch3_launch_latency", 64'(cyc - s), 64'd5);
    cnt = 0;
    while (test_rst_n[3] && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("ch3_rst_high_cycles", 64'(cnt), 64'd9);
    wait_done();
    check("tmo_fail", 64'(fail_mask), 64'h0008);
    check("tmo_tmo", 64'(timeout_mask), 64'h0008);
    check("tmo_pass", 64'(pass_mask), 64'h0000);
    check("tmo_total", 64'(total_cycles), 64'd25);

    // 4. done coincides with timeout; stray done on a not-yet-active channel
    exp_q.push_back(IW'(0)); exp_q.push_back(IW'(5));
    start_run(16'h0021, s);
    wait_launch(0);
    repeat (3) @(negedge clk);
    test_done[5] = 1'b1; test_pass[5] = 1'b1;
    @(negedge clk);
    test_done[5] = 1'b0; test_pass[5] = 1'b0;
    repeat (4) @(negedge clk);
    test_done[0] = 1'b1; test_pass[0] = 1'b1;
    @(negedge clk);
    test_done[0] = 1'b0; test_pass[0] = 1'b0;
    check("tie_pass_bit0", 64'(pass_mask), 64'h0001);
    check("tie_tmo_none", 64'(timeout_mask), 64'h0000);
    wait_done();
    check("tie_final_pass", 64'(pass_mask), 64'h0001);
    check("tie_final_fail", 64'(fail_mask), 64'h0020);
    check("tie_final_tmo", 64'(timeout_mask), 64'h0020);

    // 5a. start while busy is ignored
    exp_q.push_back(IW'(0)); exp_q.push_back(IW'(1));
    start_run(16'h0003, s);
    wait_launch(0);
    @(negedge clk);
    start = 1'b1; enable_mask = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    test_done[0] = 1'b1; test_pass[0] = 1'b1;
    @(negedge clk);
    test_done[0] = 1'b0; test_pass[0] = 1'b0;
    wait_launch(1);
    respond(1, 0, 1'b0, d);
    wait_done();
    check("busy_start_pass", 64'(pass_mask), 64'h0001);
    check("busy_start_fail", 64'(fail_mask), 64'h0002);

    // 5b. reset during WAIT on ch1 aborts
    exp_q.push_back(IW'(0)); exp_q.push_back(IW'(1));
    start_run(16'h0003, s);
    wait_launch(0);
    respond(0, 1, 1'b1, d);
    wait_launch(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_all_done", 64'(all_done), 64'd0);
    check("abort_masks", 64'({pass_mask, fail_mask, timeout_mask}), 64'd0);
    check("abort_test_rst_n", 64'(test_rst_n), 64'd0);
    check("abort_cur_idx", 64'(cur_idx), 64'd0);
    check("abort_total", 64'(total_cycles), 64'd0);

    // 5c. start from DONE clears results and reruns
    exp_q.push_back(IW'(0));
    start_run(16'h0001, s);
    wait_launch(0);
    respond(0, 0, 1'b1, d);
    wait_done();
    check("rerun_prev_pass", 64'(pass_mask), 64'h0001);
    exp_q.push_back(IW'(1));
    start_run(16'h0002, s);
    check("rerun_cleared", 64'({pass_mask, fail_mask, timeout_mask}), 64'd0);
    check("rerun_busy", 64'(busy), 64'd1);
    wait_launch(1);
    respond(1, 0, 1'b1, d);
    wait_done();
    check("rerun_pass", 64'(pass_mask), 64'h0002);

    // 6. skip spacing between ch0 and ch15
    exp_q.push_back(IW'(0)); exp_q.push_back(IW'(15));
    b0 = busy_seen;
    start_run(16'h8001, s);
    wait_launch(0);
    respond(0, 4, 1'b1, d);
    wait_launch(15);
    // one cycle to leave WAIT, SKIP over indices 1..14, SKIP on 15, then LAUNCH
    check("skip_spacing", 64'(cyc - d), 64'd16);
    respond(15, 2, 1'b1, d);
    wait_done();
    check("skip_total", 64'(total_cycles), 64'd26);
    check("skip_total_vs_count", 64'(total_cycles), 64'(busy_seen - b0));
    check("skip_pass", 64'(pass_mask), 64'h8001);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
